// File: rtl/bus_frame_collector.sv
// Reassembles the byte-serial AES/SHA bus stream into {address, opcode} command words.
// Completed words are tagged with their source engine and queued in a small FIFO for the consumer.
module bus_frame_collector #(
    parameter int unsigned ADDRW = 24,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             byte_in,
    input  logic                   aes_grant,
    input  logic                   sha_grant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_src,
    output logic [7:0]             out_opcode,
    output logic [ADDRW-1:0]       out_addr,
    output logic                   frame_err,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned NBYTES = (ADDRW + 8) / 8;
    localparam int unsigned WORDW  = ADDRW + 8;
    localparam int unsigned CNTW   = $clog2(NBYTES);
    localparam int unsigned PTRW   = $clog2(DEPTH);

    localparam logic [CNTW-1:0] LAST_SLOT = CNTW'(NBYTES - 1);
    localparam logic [PTRW:0]   FULL_CNT  = (PTRW + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              src_q, src_d;
    logic [WORDW-1:0]  word_q, word_d;
    logic              err_q, err_d;
    logic              aes_dly_q, sha_dly_q;
    logic              byte_vld, byte_bad, byte_src, mid_frame;
    logic              push;

    logic [WORDW:0]    mem_q [DEPTH];
    logic [PTRW-1:0]   wr_q, rd_q;
    logic [PTRW:0]     fcnt_q, fcnt_d;
    logic              ovf_q;
    logic              full, pop, wr_en;

    // Grants lead their data by one cycle, so the delayed grants qualify byte_in.
    assign byte_vld  = aes_dly_q | sha_dly_q;
    assign byte_bad  = aes_dly_q & sha_dly_q;
    assign byte_src  = sha_dly_q;
    assign mid_frame = (state_q == S_COLLECT) && (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        word_d  = word_q;
        err_d   = 1'b0;
        push    = 1'b0;

        if (byte_bad) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
        end else if (!byte_vld) begin
            err_d   = mid_frame;
            cnt_d   = '0;
            state_d = S_IDLE;
        end else if (!mid_frame || (byte_src != src_q)) begin
            // A source change mid-frame discards the partial word and restarts with this byte.
            err_d       = mid_frame;
            word_d[7:0] = byte_in;
            src_d       = byte_src;
            cnt_d       = CNTW'(1);
            state_d     = S_COLLECT;
        end else begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (cnt_q == CNTW'(k)) begin
                    word_d[8*k +: 8] = byte_in;
                end
            end
            if (cnt_q == LAST_SLOT) begin
                push  = 1'b1;
                cnt_d = '0;
                // A grant now means a byte next cycle, so a back-to-back frame needs no IDLE gap.
                state_d = (aes_grant | sha_grant) ? S_COLLECT : S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            src_q     <= 1'b0;
            word_q    <= '0;
            err_q     <= 1'b0;
            aes_dly_q <= 1'b0;
            sha_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            word_q    <= word_d;
            err_q     <= err_d;
            aes_dly_q <= aes_grant;
            sha_dly_q <= sha_grant;
        end
    end

    assign full      = (fcnt_q == FULL_CNT);
    assign out_valid = (fcnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);

    always_comb begin
        fcnt_d = fcnt_q;
        if (wr_en && !pop) begin
            fcnt_d = fcnt_q + 1'b1;
        end else if (!wr_en && pop) begin
            fcnt_d = fcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_q] <= {src_d, word_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            if (wr_en) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign {out_src, out_addr, out_opcode} = mem_q[rd_q];
    assign frame_err  = err_q;
    assign overflow   = ovf_q;
    assign fifo_count = fcnt_q;

endmodule

// File: tb/tb_bus_frame_collector.sv
// Self-checking bench for bus_frame_collector: a directed vector table, corner-case sequences,
// and randomized traffic compared every cycle against a queue-based frame model.
module tb_bus_frame_collector;

    localparam int ADDRW = 24;
    localparam int DEPTH = 2;
    localparam int NB    = (ADDRW + 8) / 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       byte_in = 8'h00;
    logic             aes_grant = 1'b0;
    logic             sha_grant = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid, out_src, frame_err, overflow;
    logic [7:0]       out_opcode;
    logic [ADDRW-1:0] out_addr;
    logic [1:0]       fifo_count;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    bus_frame_collector #(.ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in),
        .aes_grant(aes_grant), .sha_grant(sha_grant),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_opcode(out_opcode), .out_addr(out_addr),
        .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: bytes seen this cycle are the ones granted on the previous cycle.
    bit          m_ad = 1'b0, m_sd = 1'b0, m_err = 1'b0, m_ovf = 1'b0, cur_src = 1'b0;
    logic [7:0]  cur[$];
    logic [32:0] m_fifo[$];

    always @(posedge clk or negedge rst_n) begin
        bit          m_pop, done;
        logic [31:0] w;
        if (!rst_n) begin
            m_ad = 1'b0; m_sd = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
            cur.delete();
            m_fifo.delete();
        end else begin
            m_pop = (m_fifo.size() > 0) && out_ready;
            done  = 1'b0;
            w     = '0;
            m_err = 1'b0;
            if (m_ad && m_sd) begin
                m_err = 1'b1;
                cur.delete();
            end else if (m_ad || m_sd) begin
                if (cur.size() > 0 && cur_src != m_sd) begin
                    m_err = 1'b1;
                    cur.delete();
                end
                cur.push_back(byte_in);
                cur_src = m_sd;
                if (cur.size() == NB) begin
                    for (int k = 0; k < NB; k++) w = w | (32'(cur[k]) << (8 * k));
                    done = 1'b1;
                    cur.delete();
                end
            end else if (cur.size() > 0) begin
                m_err = 1'b1;
                cur.delete();
            end
            if (m_pop) void'(m_fifo.pop_front());
            if (done) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back({cur_src, w});
                else m_ovf = 1'b1;
            end
            m_ad = aes_grant;
            m_sd = sha_grant;
        end
    end

    always @(negedge clk) begin
        logic [32:0] eh, ah;
        if (chk_en) begin
            eh = (m_fifo.size() > 0) ? m_fifo[0] : 33'h0;
            ah = out_valid ? {out_src, out_addr, out_opcode} : 33'h0;
            check("model", {out_valid, fifo_count, overflow, frame_err, ah},
                  {m_fifo.size() > 0, 2'(m_fifo.size()), m_ovf, m_err, eh});
        end
    end

    logic [32:0] popped[$];
    int          err_cnt = 0;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) popped.push_back({out_src, out_addr, out_opcode});
        if (rst_n && frame_err) err_cnt++;
    end

    task automatic drive(input bit a, input bit s, input logic [7:0] b, input bit r);
        @(negedge clk);
        aes_grant = a;
        sha_grant = s;
        byte_in   = b;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Grant cycle k uses srcs[k]; its byte is driven on the following cycle.
    task automatic stream(input bit srcs[$], input logic [7:0] bytes[$], input bit r);
        for (int k = 0; k <= srcs.size(); k++) begin
            bit g;
            g = (k < srcs.size());
            drive(g && !srcs[k], g && srcs[k], (k > 0) ? bytes[k-1] : 8'h00, r);
        end
    endtask

    task automatic check_head(input string name, input bit src, input logic [31:0] w);
        check(name, {out_valid, out_src, out_addr, out_opcode}, {1'b1, src, w});
    endtask

    typedef struct packed {
        logic        a;
        logic        s;
        logic [7:0]  b;
        logic        r;
        logic        ev;
        logic [1:0]  ecnt;
        logic        eerr;
        logic        es;
        logic [7:0]  eop;
        logic [23:0] eaddr;
    } vec_t;

    vec_t tv[15];
    bit   sq[$];
    logic [7:0] bq[$];

    initial begin
        tv[0]  = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[1]  = {1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[2]  = {1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[3]  = {1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[4]  = {1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h11, 24'h443322};
        tv[5]  = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h11, 24'h443322};
        tv[6]  = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[7]  = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[8]  = {1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[9]  = {1'b0, 1'b0, 8'h66, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[10] = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 24'h000000};
        tv[11] = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[12] = {1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};
        tv[13] = {1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 24'h000000};
        tv[14] = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 24'h000000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {out_valid, fifo_count, overflow, frame_err, out_src, out_opcode, out_addr}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 15; i++) begin
            drive(tv[i].a, tv[i].s, tv[i].b, tv[i].r);
            check($sformatf("vec%0d", i),
                  {out_valid, fifo_count, frame_err, out_valid ? {out_src, out_opcode, out_addr} : 33'h0},
                  {tv[i].ev, tv[i].ecnt, tv[i].eerr, tv[i].ev ? {tv[i].es, tv[i].eop, tv[i].eaddr} : 33'h0});
        end

        // Back-to-back AES then SHA with the consumer always ready.
        popped.delete();
        err_cnt = 0;
        sq = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        stream(sq, bq, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
        check("b2b_count", 64'(popped.size()), 64'd2);
        check("b2b_word0", 64'(popped[0]), {31'h0, 1'b0, 32'h04030201});
        check("b2b_word1", 64'(popped[1]), {31'h0, 1'b1, 32'h08070605});
        check("b2b_noerr", 64'(err_cnt), 64'd0);

        // Grant dropped after two bytes, then a clean frame.
        err_cnt = 0;
        sq = {1'b0, 1'b0};
        bq = {8'h55, 8'h66};
        stream(sq, bq, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("drop_err", 64'(err_cnt), 64'd1);
        check("drop_empty", {out_valid, fifo_count}, 64'h0);
        sq = {1'b0, 1'b0, 1'b0, 1'b0};
        bq = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
        stream(sq, bq, 1'b0);
        check_head("drop_next", 1'b0, 32'hC3C2C1C0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // SHA takes over after three AES bytes.
        err_cnt = 0;
        sq = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bq = {8'hE1, 8'hE2, 8'hE3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        stream(sq, bq, 1'b0);
        check("switch_err", 64'(err_cnt), 64'd1);
        check("switch_cnt", 64'(fifo_count), 64'd1);
        check_head("switch_head", 1'b1, 32'hA3A2A1A0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // Three frames with the consumer stalled: third is dropped.
        sq = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bq = {8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33};
        stream(sq, bq, 1'b0);
        check("ovf_cnt", 64'(fifo_count), 64'd2);
        check("ovf_flag", 64'(overflow), 64'd1);
        check_head("ovf_head", 1'b0, 32'h13121110);
        popped.delete();
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_drain", 64'(popped.size()), 64'd2);
        check("ovf_word0", 64'(popped[0]), {31'h0, 1'b0, 32'h13121110});
        check("ovf_word1", 64'(popped[1]), {31'h0, 1'b0, 32'h23222120});
        check("ovf_sticky", {overflow, fifo_count}, 64'h4);

        // Reset mid-frame with one word queued.
        sq = {1'b0, 1'b0, 1'b0, 1'b0};
        bq = {8'h5A, 8'h5B, 8'h5C, 8'h5D};
        stream(sq, bq, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'hB0, 1'b0);
        #1;
        rst_n = 1'b0;
        aes_grant = 1'b0;
        sha_grant = 1'b0;
        #1;
        check("rst_mid", {out_valid, fifo_count, overflow, frame_err, out_src, out_opcode, out_addr}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sq = {1'b1, 1'b1, 1'b1, 1'b1};
        bq = {8'hC5, 8'hC6, 8'hC7, 8'hC8};
        stream(sq, bq, 1'b0);
        check_head("rst_after", 1'b1, 32'hC8C7C6C5);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized traffic; the per-cycle model comparison does the checking.
        begin
            bit cs, a, s, r;
            int pick;
            cs = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                pick = $urandom_range(0, 99);
                if (pick < 3) begin
                    a = 1'b1; s = 1'b1;
                end else if (pick < 10) begin
                    a = 1'b0; s = 1'b0;
                end else begin
                    if (pick < 15) cs = ~cs;
                    a = ~cs; s = cs;
                end
                if (((i / 500) % 2) == 1) r = ($urandom_range(0, 3) == 0);
                else r = ($urandom_range(0, 9) != 0);
                drive(a, s, 8'($urandom), r);
            end
        end
        repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
